// File: rtl/goe_in_arbiter_if.sv
// rtl/goe_in_arbiter_if.sv - source-side and goe-side signal bundle for goe_in_arbiter
//
// Purpose : groups the two packet sources (0 = UDA pipeline, 1 = CPU injection)
//           and the merged goe input stream into one bundle.
// Modports: master - packet source side (drives requests and words, sees grants
//                    and the merged stream)
//           slave  - arbiter side (goe_in_arbiter)
// Signals : in_req_x, out_gnt_x, in_data_wr_x, in_data_x[133:0],
//           in_valid_wr_x, in_valid_x, out_goe_data_wr, out_goe_data[133:0],
//           out_goe_valid_wr, out_goe_valid
interface goe_in_arbiter_if;
    logic         in_req_0;
    logic         in_req_1;
    logic         out_gnt_0;
    logic         out_gnt_1;
    logic         in_data_wr_0;
    logic         in_data_wr_1;
    logic [133:0] in_data_0;
    logic [133:0] in_data_1;
    logic         in_valid_wr_0;
    logic         in_valid_wr_1;
    logic         in_valid_0;
    logic         in_valid_1;
    logic         out_goe_data_wr;
    logic [133:0] out_goe_data;
    logic         out_goe_valid_wr;
    logic         out_goe_valid;

    modport master (
        output in_req_0, in_req_1,
        output in_data_wr_0, in_data_wr_1, in_data_0, in_data_1,
        output in_valid_wr_0, in_valid_wr_1, in_valid_0, in_valid_1,
        input  out_gnt_0, out_gnt_1,
        input  out_goe_data_wr, out_goe_data, out_goe_valid_wr, out_goe_valid
    );

    modport slave (
        input  in_req_0, in_req_1,
        input  in_data_wr_0, in_data_wr_1, in_data_0, in_data_1,
        input  in_valid_wr_0, in_valid_wr_1, in_valid_0, in_valid_1,
        output out_gnt_0, out_gnt_1,
        output out_goe_data_wr, out_goe_data, out_goe_valid_wr, out_goe_valid
    );
endinterface

// File: rtl/goe_in_arbiter.sv
// rtl/goe_in_arbiter.sv - packet-granular round-robin merge of UDA and CPU streams into goe
//
// Purpose : grants one of two packet sources at a time, forwards exactly one
//           packet (head .. tail) from it to the goe input with one cycle of
//           latency, then re-arbitrates round-robin. A grant that sees no
//           head word within TIMEOUT cycles is revoked.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           bus (slave)       - per-source req/gnt/data/valid and goe stream
//           pkt_cnt_0/1       - tails forwarded per source (wrapping)
//           drop_cnt          - words discarded from any source (wrapping)
//           timeout_cnt       - grants revoked by timeout (wrapping)
// Word type in [133:132]: 01 head, 11 middle, 10 tail.
module goe_in_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1024,
    parameter logic [7:0]  LMID    = 8'd5
) (
    input  logic            clk,
    input  logic            rst,
    goe_in_arbiter_if.slave bus,
    output logic [15:0]     pkt_cnt_0,
    output logic [15:0]     pkt_cnt_1,
    output logic [15:0]     drop_cnt,
    output logic [15:0]     timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HEAD = 2'd1,
        XFER      = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          sel_q, sel_d;          // index of the source holding the grant
    logic          rr_q, rr_d;            // source with priority at next arbitration
    logic [15:0]   wait_q, wait_d;

    logic          goe_data_wr_q, goe_data_wr_d;
    logic [133:0]  goe_data_q, goe_data_d;
    logic          goe_valid_wr_q, goe_valid_wr_d;
    logic          goe_valid_q, goe_valid_d;

    logic [15:0]   pkt_cnt_0_q, pkt_cnt_0_d;
    logic [15:0]   pkt_cnt_1_q, pkt_cnt_1_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [15:0]   timeout_cnt_q, timeout_cnt_d;

    logic          g_wr;
    logic          g_vwr;
    logic          g_v;
    logic [133:0]  g_data;
    logic          fwd;
    logic          pick;
    logic [1:0]    drop_inc;

    // LMID only identifies this block for management addressing.
    logic          unused_lmid;
    assign unused_lmid = ^LMID;

    always_comb begin
        // View of whichever source currently owns (or last owned) the grant;
        // only consulted while a grant is active.
        g_wr   = sel_q ? bus.in_data_wr_1  : bus.in_data_wr_0;
        g_data = sel_q ? bus.in_data_1     : bus.in_data_0;
        g_vwr  = sel_q ? bus.in_valid_wr_1 : bus.in_valid_wr_0;
        g_v    = sel_q ? bus.in_valid_1    : bus.in_valid_0;

        state_d       = state_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        rr_d          = rr_q;
        wait_d        = wait_q;
        pkt_cnt_0_d   = pkt_cnt_0_q;
        pkt_cnt_1_d   = pkt_cnt_1_q;
        timeout_cnt_d = timeout_cnt_q;
        fwd           = 1'b0;
        pick          = 1'b0;

        // Any strobe from a source without the grant is discarded; both
        // sources may do so in the same cycle.
        drop_inc = {1'b0, bus.in_data_wr_0 & ~gnt_q[0]}
                 + {1'b0, bus.in_data_wr_1 & ~gnt_q[1]};

        case (state_q)
            IDLE: begin
                if (bus.in_req_0 || bus.in_req_1) begin
                    if (rr_q) begin
                        pick = bus.in_req_1 ? 1'b1 : 1'b0;
                    end else begin
                        pick = bus.in_req_0 ? 1'b0 : 1'b1;
                    end
                    sel_d   = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    wait_d  = 16'd0;
                    state_d = WAIT_HEAD;
                end
            end

            WAIT_HEAD: begin
                if (g_wr) begin
                    if (g_data[133:132] == TYPE_HEAD) begin
                        fwd     = 1'b1;
                        state_d = XFER;
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                    end
                end else if (wait_q == TIMEOUT - 16'd1) begin
                    gnt_d         = 2'b00;
                    timeout_cnt_d = timeout_cnt_q + 16'd1;
                    rr_d          = ~sel_q;
                    state_d       = IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            XFER: begin
                // Everything the granted source strobes is passed through,
                // including a stray head in mid-packet.
                fwd = g_wr | g_vwr;
                if (g_wr && (g_data[133:132] == TYPE_TAIL)) begin
                    gnt_d   = 2'b00;
                    rr_d    = ~sel_q;
                    state_d = IDLE;
                    if (sel_q) begin
                        pkt_cnt_1_d = pkt_cnt_1_q + 16'd1;
                    end else begin
                        pkt_cnt_0_d = pkt_cnt_0_q + 16'd1;
                    end
                end
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase

        drop_cnt_d = drop_cnt_q + {14'd0, drop_inc};

        // Idle cycles on the goe side are driven to all zeros.
        goe_data_wr_d  = fwd & g_wr;
        goe_data_d     = (fwd & g_wr) ? g_data : 134'd0;
        goe_valid_wr_d = fwd & g_vwr;
        goe_valid_d    = fwd & g_vwr & g_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_q          <= 2'b00;
            sel_q          <= 1'b0;
            rr_q           <= 1'b0;
            wait_q         <= 16'd0;
            goe_data_wr_q  <= 1'b0;
            goe_data_q     <= 134'd0;
            goe_valid_wr_q <= 1'b0;
            goe_valid_q    <= 1'b0;
            pkt_cnt_0_q    <= 16'd0;
            pkt_cnt_1_q    <= 16'd0;
            drop_cnt_q     <= 16'd0;
            timeout_cnt_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            sel_q          <= sel_d;
            rr_q           <= rr_d;
            wait_q         <= wait_d;
            goe_data_wr_q  <= goe_data_wr_d;
            goe_data_q     <= goe_data_d;
            goe_valid_wr_q <= goe_valid_wr_d;
            goe_valid_q    <= goe_valid_d;
            pkt_cnt_0_q    <= pkt_cnt_0_d;
            pkt_cnt_1_q    <= pkt_cnt_1_d;
            drop_cnt_q     <= drop_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    assign bus.out_gnt_0        = gnt_q[0];
    assign bus.out_gnt_1        = gnt_q[1];
    assign bus.out_goe_data_wr  = goe_data_wr_q;
    assign bus.out_goe_data     = goe_data_q;
    assign bus.out_goe_valid_wr = goe_valid_wr_q;
    assign bus.out_goe_valid    = goe_valid_q;

    assign pkt_cnt_0   = pkt_cnt_0_q;
    assign pkt_cnt_1   = pkt_cnt_1_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/goe_in_arbiter.md
Name: goe_in_arbiter

Overview:
- Packet-granular round-robin arbiter that merges two 134-bit packet sources into the single goe input stream:
  - source 0: the UDA pipeline;
  - source 1: the CPU injection path.
- Grants one source at a time and forwards one complete packet (head through tail) before re-arbitrating.
- Provides grant timeout, drop accounting and per-source packet counters for management reads.

Parameters:
- TIMEOUT, 16'd1024: cycles a grant may wait for a head word before it is revoked.
- LMID, 8'd5: local module ID; carried for management addressing, no datapath effect.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_req_0 / in_req_1  in  1  source requests a packet slot; level, held until granted.
- out_gnt_0 / out_gnt_1  out  1  grant; registered, at most one high.
- in_data_wr_0 / in_data_wr_1  in  1  data word strobe.
- in_data_0 / in_data_1  in  134  word; [133:132] 01 = head, 11 = middle, 10 = tail.
- in_valid_wr_0 / in_valid_wr_1  in  1  valid strobe; accompanies the tail.
- in_valid_0 / in_valid_1  in  1  packet valid flag.
- out_goe_data_wr  out  1  to goe in_goe_data_wr.
- out_goe_data  out  134  to goe in_goe_data.
- out_goe_valid_wr  out  1  to goe in_goe_valid_wr.
- out_goe_valid  out  1  to goe in_goe_valid.
- pkt_cnt_0 / pkt_cnt_1  out  16  tails forwarded per source; wraps.
- drop_cnt  out  16  words discarded (any source); wraps.
- timeout_cnt  out  16  grants revoked by timeout; wraps.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, rr_ptr=0 (source 0 has priority first), wait counter 0. Reset mid-packet truncates the packet; there is no recovery tail.
- States: IDLE, WAIT_HEAD, XFER.
- IDLE:
  - If any in_req is high, grant a source: the rr_ptr source if it requests, else the other.
  - out_gnt_x goes high on the next edge; move to WAIT_HEAD and clear the wait counter.
- WAIT_HEAD:
  - Granted-source word with [133:132]=01: forward it, move to XFER.
  - Granted-source word that is not a head: discard, drop_cnt+1, stay.
  - Otherwise wait counter +1. When it reaches TIMEOUT-1: drop gnt, timeout_cnt+1, rr_ptr = other source, go to IDLE.
- XFER:
  - Forward every granted-source strobe cycle.
  - On a tail word with data_wr: forward it together with that cycle's valid_wr/valid. On the next edge: gnt low, pkt_cnt_x+1, rr_ptr = other source, go to IDLE.
  - A head arriving mid-packet is forwarded unchanged (no repair).
- Forwarding:
  - Registered, 1-cycle latency: out_goe_* = the granted source's in_* of the previous cycle.
  - Cycles with no strobe drive out_goe_data_wr=0, out_goe_valid_wr=0 and out_goe_data=0.
- Non-granted source:
  - Any in_data_wr high from it is discarded with drop_cnt+1.
  - If both sources strobe illegally in the same cycle, drop_cnt+2.
- Grant timing:
  - Minimum re-arbitration gap is 1 idle cycle after gnt falls, so back-to-back packets from alternating sources are spaced ≥2 cycles at the goe input.
  - Both requesting continuously gives strict alternation 0,1,0,1.
- Single-word packet: a tail without a prior head is not legal. A head immediately followed by a tail is a 2-word packet.
- Counter overflow: 16'hFFFF+1 wraps to 0.
- Simultaneous tail and new request: the request is honoured only in IDLE, never in the same cycle as the tail.

Test Plan:
- Only req_0 asserted, 3-word packet (01,11,10) sent after gnt_0 → out_goe shows the same 3 words 1 cycle later, valid_wr with the tail, pkt_cnt_0=1, gnt_0 low the cycle after the tail.
- req_0 and req_1 held high, each sending 4-word packets ×4 → order at goe is 0,1,0,1,0,1,0,1; pkt_cnt_0=pkt_cnt_1=4; gnt_0 and gnt_1 never high together.
- Source 1 strobes 2 words while source 0 holds the grant → those words are absent at the output, drop_cnt=2, source 0's packet is intact.
- gnt_0 given, source 0 never sends a head, TIMEOUT=16 → gnt_0 falls after 16 cycles, timeout_cnt=1, pending req_1 is granted next.
- Granted source sends a middle word (11) before its head → word dropped, drop_cnt=1; the following head+tail is forwarded, pkt_cnt=1.
- rst pulsed during XFER → all outputs 0 immediately, FSM in IDLE; the next request from source 0 is granted normally.
